// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU op codes, R-type
// field constants and the bundle held in decode.
package decode_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(
    input logic [31:0] ins
  );
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       base;
    logic       alt;
    logic       ok;
    f7   = ins[31:25];
    f3   = ins[14:12];
    base = (f7 == F7_BASE);
    alt  = (f7 == F7_ALT);
    ok   = 1'b0;
    d.alu_op = ALU_NOP;
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    if (ins[6:0] == OPC_RTYPE) begin
      unique case (f3)
        3'd0: begin
          if (base) begin
            d.alu_op = ALU_ADD; ok = 1'b1;
          end else if (alt) begin
            d.alu_op = ALU_SUB; ok = 1'b1;
          end
        end
        3'd1: if (base) begin
          d.alu_op = ALU_SLL; ok = 1'b1;
        end
        3'd2: if (base) begin
          d.alu_op = ALU_SLT; ok = 1'b1;
        end
        3'd3: if (base) begin
          d.alu_op = ALU_SLTU; ok = 1'b1;
        end
        3'd4: if (base) begin
          d.alu_op = ALU_XOR; ok = 1'b1;
        end
        3'd5: begin
          if (base) begin
            d.alu_op = ALU_SRL; ok = 1'b1;
          end else if (alt) begin
            d.alu_op = ALU_SRA; ok = 1'b1;
          end
        end
        3'd6: if (base) begin
          d.alu_op = ALU_OR; ok = 1'b1;
        end
        3'd7: if (base) begin
          d.alu_op = ALU_AND; ok = 1'b1;
        end
      endcase
    end
    if (!ok) d.alu_op = ALU_NOP;
    d.illegal = !ok;
    d.rd      = ok ? ins[11:7] : 5'd0;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two async reads, one sync
// write, x0 reads as zero, whole file cleared on reset.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && waddr_i != 5'd0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0
                                       : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0
                                       : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// RV32I R-type decode stage: operand read with
// write-back bypass and a one-entry output register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  instruction_code,
  output logic             in_ready,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       ex_alu_op,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam dec_t DEC_RST = '{
    alu_op: ALU_NOP, rd: 5'd0, rs1: 5'd0,
    rs2: 5'd0, illegal: 1'b0
  };

  dec_t            dec;
  dec_t            bun_q, bun_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rf_a, rf_b, fwd_a, fwd_b;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            wb_hit, accept;

  assign dec    = decode(instruction_code[31:0]);
  assign wb_hit = wb_en && (wb_rd != 5'd0);

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wb_en),
    .waddr_i (wb_rd),
    .wdata_i (wb_data),
    .raddr1_i(dec.rs1),
    .raddr2_i(dec.rs2),
    .rdata1_o(rf_a),
    .rdata2_o(rf_b)
  );

  // Same-edge write-back wins over the stale file value
  assign fwd_a = (wb_hit && wb_rd == dec.rs1) ? wb_data
                                              : rf_a;
  assign fwd_b = (wb_hit && wb_rd == dec.rs2) ? wb_data
                                              : rf_b;

  assign in_ready = !valid_q || ex_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      bun_d   = dec;
      a_d     = fwd_a;
      b_d     = fwd_b;
      if (dec.illegal && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Held bundle tracks write-backs to its sources
      if (wb_hit && wb_rd == bun_q.rs1) a_d = wb_data;
      if (wb_hit && wb_rd == bun_q.rs2) b_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      bun_q   <= DEC_RST;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_op     = bun_q.alu_op;
  assign ex_rd         = bun_q.rd;
  assign ex_rs1_data   = a_q;
  assign ex_rs2_data   = b_q;
  assign ex_illegal    = bun_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus
// handshake, bypass, saturation and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instruction_code;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic        ex_illegal;
  logic [7:0]  illegal_count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .instruction_code(instruction_code),
    .in_ready        (in_ready),
    .wb_en           (wb_en),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_alu_op       (ex_alu_op),
    .ex_rd           (ex_rd),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data),
    .ex_illegal      (ex_illegal),
    .illegal_count   (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = '0;
  endtask

  task automatic wb(input logic [4:0] r,
                    input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic chk_b(input string nm,
                       input logic [3:0] op,
                       input logic [4:0] rd,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic ill);
    chk({nm, ".valid"}, 32'(ex_valid), 32'd1);
    chk({nm, ".op"}, 32'(ex_alu_op), 32'(op));
    chk({nm, ".rd"}, 32'(ex_rd), 32'(rd));
    chk({nm, ".a"}, ex_rs1_data, a);
    chk({nm, ".b"}, ex_rs2_data, b);
    chk({nm, ".ill"}, 32'(ex_illegal), 32'(ill));
  endtask

  function automatic logic [31:0] rt(
    input logic [6:0] f7, input logic [4:0] r2,
    input logic [4:0] r1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] opc);
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [31:0] ADD_I = 32'h007302b3;

  int exp_cnt;

  initial begin
    tbl[0]  = '{rt(7'h00, 3, 2, 0, 1, R),
                4'd0, 5'd1, 32'h102, 32'h103, 1'b0};
    tbl[1]  = '{rt(7'h20, 6, 5, 0, 4, R),
                4'd1, 5'd4, 32'h105, 32'h106, 1'b0};
    tbl[2]  = '{rt(7'h00, 9, 8, 1, 7, R),
                4'd2, 5'd7, 32'h108, 32'h109, 1'b0};
    tbl[3]  = '{rt(7'h00, 12, 11, 2, 10, R),
                4'd3, 5'd10, 32'h10b, 32'h10c, 1'b0};
    tbl[4]  = '{rt(7'h00, 15, 14, 3, 13, R),
                4'd4, 5'd13, 32'h10e, 32'h10f, 1'b0};
    tbl[5]  = '{rt(7'h00, 18, 17, 4, 16, R),
                4'd5, 5'd16, 32'h111, 32'h112, 1'b0};
    tbl[6]  = '{rt(7'h00, 21, 20, 5, 19, R),
                4'd6, 5'd19, 32'h114, 32'h115, 1'b0};
    tbl[7]  = '{rt(7'h20, 24, 23, 5, 22, R),
                4'd7, 5'd22, 32'h117, 32'h118, 1'b0};
    tbl[8]  = '{rt(7'h00, 27, 26, 6, 25, R),
                4'd8, 5'd25, 32'h11a, 32'h11b, 1'b0};
    tbl[9]  = '{rt(7'h00, 30, 29, 7, 28, R),
                4'd9, 5'd28, 32'h11d, 32'h11e, 1'b0};
    tbl[10] = '{rt(7'h20, 0, 31, 1, 3, R),
                4'd15, 5'd0, 32'h11f, 32'h0, 1'b1};
    tbl[11] = '{rt(7'h00, 2, 1, 0, 5, 7'h13),
                4'd15, 5'd0, 32'h101, 32'h102, 1'b1};
    tbl[12] = '{rt(7'h01, 31, 0, 0, 6, R),
                4'd15, 5'd0, 32'h0, 32'h11f, 1'b1};

    idle();
    instruction_code = '0;
    ex_ready = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.op", 32'(ex_alu_op), 32'd15);
    chk("rst.rd", 32'(ex_rd), 32'd0);
    chk("rst.a", ex_rs1_data, 32'd0);
    chk("rst.b", ex_rs2_data, 32'd0);
    chk("rst.ill", 32'(ex_illegal), 32'd0);
    chk("rst.cnt", 32'(illegal_count), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);

    // basic ADD
    wb(6, 32'd5);
    wb(7, 32'd3);
    in_valid = 1'b1; instruction_code = ADD_I;
    step();
    chk_b("add", 4'd0, 5'd5, 32'd5, 32'd3, 1'b0);

    // SUB then back-to-back SRL
    in_valid = 1'b0;
    wb(9, 32'd20);
    wb(18, 32'd12);
    in_valid = 1'b1; instruction_code = 32'h41248433;
    step();
    chk_b("sub", 4'd1, 5'd8, 32'd20, 32'd12, 1'b0);
    instruction_code = 32'h01eede33;
    step();
    chk_b("srl", 4'd6, 5'd28, 32'd0, 32'd0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain.valid", 32'(ex_valid), 32'd0);

    // stall with held-operand refresh
    ex_ready = 1'b0;
    in_valid = 1'b1; instruction_code = ADD_I;
    step();
    chk_b("st0", 4'd0, 5'd5, 32'd5, 32'd3, 1'b0);
    chk("st0.rdy", 32'(in_ready), 32'd0);
    instruction_code = 32'hFFFFFFFF;
    step();
    chk_b("st1", 4'd0, 5'd5, 32'd5, 32'd3, 1'b0);
    wb(6, 32'd99);
    chk_b("st2", 4'd0, 5'd5, 32'd99, 32'd3, 1'b0);
    chk("st2.rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk("st3.rdy", 32'(in_ready), 32'd1);
    step();
    chk("st3.valid", 32'(ex_valid), 32'd0);
    chk("st3.cnt", 32'(illegal_count), 32'd0);

    // same-edge bypass
    in_valid = 1'b1; instruction_code = ADD_I;
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    step();
    wb_en = 1'b0;
    chk_b("byp", 4'd0, 5'd5, 32'd99, 32'hDEAD, 1'b0);

    // x0 writes ignored, also on the bypass path
    in_valid = 1'b0;
    wb(0, 32'hFFFFFFFF);
    in_valid = 1'b1;
    instruction_code = rt(7'h00, 0, 0, 0, 1, R);
    step();
    chk_b("x0rd", 4'd0, 5'd1, 32'd0, 32'd0, 1'b0);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    step();
    wb_en = 1'b0;
    chk_b("x0byp", 4'd0, 5'd1, 32'd0, 32'd0, 1'b0);
    in_valid = 1'b0;

    // decode table over a known register image
    for (int i = 1; i < 32; i++) begin
      wb(5'(i), 32'h100 + 32'(i));
    end
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      instruction_code = tbl[i].ins;
      step();
      chk_b($sformatf("tbl%0d", i), tbl[i].op,
            tbl[i].rd, tbl[i].a, tbl[i].b,
            tbl[i].ill);
    end
    in_valid = 1'b0;
    chk("tbl.cnt", 32'(illegal_count), 32'd3);

    // saturation of the illegal counter
    exp_cnt = 3;
    in_valid = 1'b1; instruction_code = 32'hFFFFFFFF;
    for (int k = 0; k < 300; k++) begin
      step();
      if (exp_cnt < 255) exp_cnt++;
      chk("sat.ill", 32'(ex_illegal), 32'd1);
      chk("sat.op", 32'(ex_alu_op), 32'd15);
      chk("sat.rd", 32'(ex_rd), 32'd0);
      chk("sat.cnt", 32'(illegal_count),
          32'(exp_cnt));
    end
    chk("sat.final", 32'(illegal_count), 32'd255);

    // reset while a bundle is held
    ex_ready = 1'b0;
    instruction_code = ADD_I;
    step();
    chk("hold.valid", 32'(ex_valid), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("hr.valid", 32'(ex_valid), 32'd0);
    chk("hr.cnt", 32'(illegal_count), 32'd0);
    chk("hr.op", 32'(ex_alu_op), 32'd15);
    ex_ready = 1'b1;
    in_valid = 1'b1; instruction_code = ADD_I;
    step();
    chk_b("hr.rf", 4'd0, 5'd5, 32'd0, 32'd0, 1'b0);
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
